// File: rtl/mul_vr_pkg.sv
// Shared types and defaults for the multiplier valid/ready initiator.
// The state encoding follows the multiplier controller's 2-bit style.
`timescale 1ns/1ps
package mul_vr_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    AWAIT = 2'b10
  } state_t;

  localparam int MUL_WIDTH   = 16;
  localparam int MUL_DEPTH   = 4;
  localparam int MUL_TIMEOUT = 255;
endpackage

// File: rtl/mul_vr_fifo.sv
// Operand FIFO for the multiplier initiator.
// Ports:
//   clk, rst        clock, async active-low reset
//   push_i, data_i  write request and data (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   full_o, empty_o occupancy flags, decoded from registered pointers
//   head_o          oldest entry, forced to zero when empty
`timescale 1ns/1ps
module mul_vr_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  logic [AW:0]                 wr_q, rd_q;
  logic [DEPTH-1:0][DW-1:0]    mem_q;
  logic                        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (do_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mul_vr_initiator.sv
// Initiator side of the valid/ready multiplier interface.
// Queues host operand pairs, issues them one at a time to the multiplier,
// captures each product into a one-entry response register, and aborts a
// transaction that waits too long for its product.
// Ports:
//   clk, rst                          clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_a/cmd_b   host operand push
//   mul_valid/mul_ready/mul_a/mul_b   multiplier source port
//   res_valid/res_ready/res_data      multiplier destination port
//   rsp_valid/rsp_ready/rsp_data      host response register
//   stall                             holds res_ready low
//   busy, txn_count, timeout_err      status
`timescale 1ns/1ps
module mul_vr_initiator
  import mul_vr_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int DEPTH   = MUL_DEPTH,
  parameter int TIMEOUT = MUL_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic               mul_valid,
  input  logic               mul_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [2*WIDTH-1:0] res_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  input  logic               stall,
  output logic               busy,
  output logic [7:0]         txn_count,
  output logic               timeout_err
);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t               state_q;
  logic                 mul_valid_q, rsp_valid_q, to_err_q;
  logic [2*WIDTH-1:0]   rsp_data_q, head;
  logic [7:0]           txn_q, wait_q;
  logic                 fifo_full, fifo_empty;
  logic                 issue_hs, cap, to_hit;

  mul_vr_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (cmd_valid),
    .pop_i  (issue_hs),
    .data_i ({cmd_a, cmd_b}),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  assign cmd_ready = !fifo_full;
  assign mul_a     = head[2*WIDTH-1:WIDTH];
  assign mul_b     = head[WIDTH-1:0];

  // The abort cycle never accepts a product, so a late res_valid cannot race it.
  assign to_hit    = (state_q == AWAIT) && (wait_q == TO_LIM);
  assign res_ready = (state_q == AWAIT) && !to_hit && !stall &&
                     (!rsp_valid_q || rsp_ready);
  assign issue_hs  = mul_valid_q && mul_ready;
  assign cap       = res_valid && res_ready;

  assign mul_valid   = mul_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign txn_count   = txn_q;
  assign timeout_err = to_err_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mul_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      txn_q       <= '0;
      wait_q      <= '0;
      to_err_q    <= 1'b0;
    end else begin
      // Response register: a capture in the same cycle as a host read wins.
      if (cap) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= res_data;
        txn_q       <= txn_q + 8'd1;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= ISSUE;
            mul_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_hs) begin
            state_q     <= AWAIT;
            mul_valid_q <= 1'b0;
            wait_q      <= '0;
          end
        end
        AWAIT: begin
          if (to_hit) begin
            to_err_q <= 1'b1;
            state_q  <= IDLE;
          end else if (cap) begin
            if (fifo_empty) begin
              state_q <= IDLE;
            end else begin
              state_q     <= ISSUE;
              mul_valid_q <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          mul_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_vr_initiator.sv
`timescale 1ns/1ps
module tb_mul_vr_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic        mul_valid, mul_ready = 1'b0;
  logic [15:0] mul_a, mul_b;
  logic        res_valid = 1'b0, res_ready;
  logic [31:0] res_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        stall = 1'b0, busy, timeout_err;
  logic [7:0]  txn_count;

  int n_vec = 0, n_bad = 0;
  logic [31:0] exp_q[$];

  // Multiplier responder controls
  int lat = 17;
  int drop_n = 0;

  mul_vr_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .stall(stall), .busy(busy), .txn_count(txn_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push is accepted.
  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input bit want_rsp);
    int t = 0;
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
    if (want_rsp) exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Sequential multiplier model: latches operands on the source handshake and
  // presents the product lat cycles later, holding it until accepted.
  initial begin : responder
    bit hs_i, hs_r, pend;
    int cnt;
    logic [15:0] sa, sb, pa, pb;
    pend = 0; cnt = 0; sa = '0; sb = '0; pa = '0; pb = '0;
    forever begin
      @(negedge clk); #1;
      hs_i = mul_valid && mul_ready;
      hs_r = res_valid && res_ready;
      if (hs_i) begin sa = mul_a; sb = mul_b; end
      @(posedge clk); #1;
      if (!rst) begin
        pend = 0; res_valid = 1'b0;
      end else begin
        if (hs_r) res_valid = 1'b0;
        if (hs_i) begin
          if (drop_n > 0) drop_n--;
          else begin pend = 1; cnt = lat; pa = sa; pb = sb; end
        end else if (pend) begin
          if (cnt <= 1) begin
            res_valid = 1'b1; res_data = {16'h0, pa} * {16'h0, pb}; pend = 0;
          end else cnt--;
        end
      end
    end
  end

  // Host-side scoreboard: every consumed response must match the next expected product.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk); #1;
      if (rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin e = exp_q.pop_front(); chk("rsp_order", rsp_data, e); end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    repeat (3) @(negedge clk);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_to_err", timeout_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);

    // Single op: 3*5
    mul_ready = 1'b1; lat = 17;
    push(16'd3, 16'd5, 32'd15, 1);
    chk("t1_mv_n1", mul_valid, 0);
    @(negedge clk);
    chk("t1_mv_n2", mul_valid, 1);
    chk("t1_mul_a", mul_a, 3);
    chk("t1_mul_b", mul_b, 5);
    chk("t1_busy", busy, 1);
    t = 0; while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 15);
    chk("t1_txn", txn_count, 1);
    chk("t1_busy_done", busy, 0);
    rsp_ready = 1'b1;
    @(negedge clk);

    // Backpressure: multiplier stalled, six ops
    mul_ready = 1'b0; lat = 3;
    push(16'd2, 16'd3, 32'd6, 1);
    push(16'd4, 16'd4, 32'd16, 1);
    push(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1);
    push(16'd100, 16'd200, 32'd20000, 1);
    chk("t2_full", cmd_ready, 0);
    fork
      begin
        push(16'h8000, 16'd2, 32'h00010000, 1);
        push(16'd0, 16'd77, 32'd0, 1);
      end
      begin repeat (5) @(negedge clk); mul_ready = 1'b1; end
    join
    t = 0; while (txn_count != 8'd7 && t < 500) begin @(negedge clk); t++; end
    chk("t2_txn", txn_count, 7);
    repeat (3) @(negedge clk);
    chk("t2_all_out", exp_q.size(), 0);

    // Response hold: host not reading
    rsp_ready = 1'b0; lat = 5;
    push(16'd7, 16'd9, 32'd63, 1);
    push(16'd10, 16'd11, 32'd110, 1);
    t = 0; while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("t3_first", rsp_data, 63);
    t = 0; while (!res_valid && t < 100) begin @(negedge clk); t++; end
    chk("t3_res_valid", res_valid, 1);
    chk("t3_res_ready_lo", res_ready, 0);
    repeat (4) @(negedge clk);
    chk("t3_hold_data", rsp_data, 63);
    chk("t3_hold_valid", rsp_valid, 1);
    chk("t3_still_lo", res_ready, 0);
    chk("t3_txn_hold", txn_count, 8);
    chk("t3_no_issue", mul_valid, 0);
    rsp_ready = 1'b1;
    #1 chk("t3_res_ready_hi", res_ready, 1);
    @(negedge clk);
    chk("t3_second", rsp_data, 110);
    chk("t3_valid_kept", rsp_valid, 1);
    chk("t3_txn", txn_count, 9);
    @(negedge clk);
    chk("t3_drained", rsp_valid, 0);

    // Stall hook
    stall = 1'b1; lat = 3;
    push(16'd12, 16'd13, 32'd156, 1);
    t = 0; while (!res_valid && t < 100) begin @(negedge clk); t++; end
    chk("t4_res_valid", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_stalled", res_ready, 0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1 chk("t4_release", res_ready, 1);
    @(negedge clk);
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_data", rsp_data, 156);
    chk("t4_txn", txn_count, 10);
    repeat (2) @(negedge clk);

    // Timeout: first op never answered, second must still go through
    drop_n = 1; lat = 3;
    push(16'd2, 16'd2, 32'd4, 0);
    push(16'd4, 16'd5, 32'd20, 1);
    t = 0; while (!mul_valid && t < 20) begin @(negedge clk); t++; end
    chk("t5_issue", mul_valid, 1);
    @(negedge clk);
    repeat (250) @(negedge clk);
    chk("t5_no_err_yet", timeout_err, 0);
    chk("t5_waiting", mul_valid, 0);
    t = 0; while (!timeout_err && t < 20) begin @(negedge clk); t++; end
    chk("t5_err", timeout_err, 1);
    chk("t5_idle_mv", mul_valid, 0);
    chk("t5_no_rsp", rsp_valid, 0);
    chk("t5_busy", busy, 1);
    @(negedge clk);
    chk("t5_next_issue", mul_valid, 1);
    chk("t5_next_ab", {mul_a, mul_b}, 32'h00040005);
    t = 0; while (txn_count != 8'd11 && t < 100) begin @(negedge clk); t++; end
    chk("t5_txn", txn_count, 11);
    chk("t5_err_sticky", timeout_err, 1);
    repeat (3) @(negedge clk);

    // Reset mid-AWAIT with three ops queued
    lat = 100;
    push(16'd1, 16'd1, 32'd1, 0);
    push(16'd2, 16'd2, 32'd4, 0);
    push(16'd3, 16'd3, 32'd9, 0);
    push(16'd4, 16'd4, 32'd16, 0);
    chk("t6_busy", busy, 1);
    chk("t6_mv_await", mul_valid, 0);
    rst = 1'b0;
    #1;
    chk("t6_mul_valid", mul_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_txn", txn_count, 0);
    chk("t6_to_err", timeout_err, 0);
    chk("t6_busy_rst", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_stay_idle", mul_valid, 0);
    chk("t6_fifo_empty", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_data", rsp_data, 0);
    chk("t6_ab_zero", {mul_a, mul_b}, 0);
    chk("end_scoreboard", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
